// File: rtl/calc_dm_stage_register.sv
// rtl/calc_dm_stage_register.sv - Calc-to-DM pipeline register with multi-cycle load hold
// Opcode 34 loads occupy DM for MEM_LATENCY cycles while StallUp freezes the upstream stages.
module calc_dm_stage_register #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       CalcValid,
  input  logic [5:0] CalcOp,
  input  logic [4:0] CalcDs,
  input  logic       Flush,
  output logic [5:0] DmOp,
  output logic [4:0] DmDs,
  output logic       DmEnable,
  output logic       DmWritesReg,
  output logic       StallUp,
  output logic       MemBusy
);

  localparam logic [5:0]       LOAD_OP  = 6'd34;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(MEM_LATENCY - 1);
  localparam logic             HAS_WAIT = (MEM_LATENCY > 1);

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } dmStateT;

  dmStateT          state;
  logic [CNT_W-1:0] waitCnt;
  logic             captureValid;
  logic             captureWrites;
  logic             startWait;

  function automatic logic isWriteOp(input logic [5:0] op);
    logic w;
    w = 1'b0;
    case (op)
      6'd0, 6'd8, 6'd9, 6'd10, 6'd12, 6'd14, 6'd34: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  always_comb begin
    captureValid  = CalcValid & ~Flush;
    captureWrites = captureValid & isWriteOp(CalcOp) & (CalcDs != 5'd0);
    startWait     = captureValid & (CalcOp == LOAD_OP) & HAS_WAIT;
  end

  // In LOAD_WAIT every DM register holds; Flush is ignored because the load is older than the redirect.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state       <= RUN;
      waitCnt     <= '0;
      DmOp        <= '0;
      DmDs        <= '0;
      DmEnable    <= 1'b0;
      DmWritesReg <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          DmOp        <= CalcOp;
          DmDs        <= CalcDs;
          DmEnable    <= captureValid;
          DmWritesReg <= captureWrites;
          if (startWait) begin
            state   <= LOAD_WAIT;
            waitCnt <= WAIT_CNT;
          end
        end
        LOAD_WAIT: begin
          if (waitCnt <= CNT_W'(1)) begin
            state   <= RUN;
            waitCnt <= '0;
          end else begin
            waitCnt <= waitCnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

  assign StallUp = (state == LOAD_WAIT);
  assign MemBusy = (state == LOAD_WAIT);

endmodule

// File: doc/calc_dm_stage_register.md
Name: calc_dm_stage_register

Overview:
- Pipeline register between the Calc stage and the DM stage.
- Captures the Calc-stage opcode and destination register, and presents them as DmOp/DmDs/DmEnable to the DM-stage data-forwarding logic.
- Holds the DM stage for multi-cycle loads (opcode 34), generates the upstream stall, and inserts a bubble on flush.

Parameters:
- MEM_LATENCY, 2, total cycles an opcode-34 load occupies the DM stage; legal 1..15; 1 means no wait.
- CNT_W, 4, width of the wait counter; must hold MEM_LATENCY-1.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- ResetN  input  1  asynchronous active-low reset.
- CalcValid  input  1  Calc stage holds a real instruction.
- CalcOp  input  6  Calc-stage opcode.
- CalcDs  input  5  Calc-stage destination register.
- Flush  input  1  kill the instruction entering DM (branch redirect).
- DmOp  output  6  registered opcode in DM stage.
- DmDs  output  5  registered destination in DM stage.
- DmEnable  output  1  DM stage valid and forwardable; drives the forwarding unit Enable.
- DmWritesReg  output  1  registered: DM op is in {0,8,9,10,12,14,34} and DmDs != 0.
- StallUp  output  1  hold IF/RR/Calc this cycle.
- MemBusy  output  1  FSM in LOAD_WAIT.

Behaviour:
- Reset (ResetN=0, asynchronous): DmOp=0, DmDs=0, DmEnable=0, DmWritesReg=0, state=RUN, counter=0. StallUp=0 and MemBusy=0 while in reset.
- FSM states: RUN, LOAD_WAIT.
- RUN, each rising edge:
  - DmOp<=CalcOp, DmDs<=CalcDs, DmEnable<=CalcValid & ~Flush.
  - DmWritesReg is computed from the captured values, gated by CalcValid & ~Flush.
- RUN -> LOAD_WAIT: when the captured instruction is valid, CalcOp==34 and MEM_LATENCY>1. Counter is loaded with MEM_LATENCY-1.
- LOAD_WAIT:
  - DmOp/DmDs/DmEnable/DmWritesReg hold.
  - StallUp=1 and MemBusy=1, both combinational from state.
  - Counter decrements by 1 each edge. When counter==1 at an edge, the next state is RUN and the counter goes to 0.
  - Total DM occupancy is exactly MEM_LATENCY cycles.
- StallUp=0 in RUN. Upstream stages sample StallUp in the same cycle, so no instruction is lost or duplicated.
- Flush:
  - In RUN: the incoming instruction becomes a bubble (DmEnable=0, DmWritesReg=0). DmOp/DmDs still load CalcOp/CalcDs but are don't-care.
  - A flushed opcode-34 does not enter LOAD_WAIT.
  - In LOAD_WAIT, Flush is ignored: the load in DM is older than the redirect and completes.
- CalcValid=0 in RUN: bubble, same as flush; no LOAD_WAIT.
- MEM_LATENCY=1: the FSM never leaves RUN and StallUp is constant 0.
- Back-to-back loads: the second load is held upstream by StallUp. It is captured on the edge that returns to RUN and starts its own LOAD_WAIT.
- Reset asserted mid-LOAD_WAIT: immediate return to reset values. After release, the first edge captures in RUN.
- Destination 0: DmWritesReg=0 even for writing opcodes. DmEnable still follows valid.
- There is no combinational path from Calc inputs to any output; StallUp depends on state only.

Test Plan:
1. Reset then CalcValid=1, CalcOp=8, CalcDs=5 -> one edge later DmOp=8, DmDs=5, DmEnable=1, DmWritesReg=1, StallUp=0.
2. MEM_LATENCY=2, CalcOp=34, CalcDs=7 -> DmOp=34 for 2 cycles; StallUp=1 for exactly 1 cycle; the next instruction (op 0, ds 3) appears in DM on the 3rd edge.
3. MEM_LATENCY=4, two consecutive op-34 loads (ds 4, ds 6) -> ds 4 held 4 cycles, then ds 6 held 4 cycles; StallUp high for 3+3 cycles; no instruction dropped.
4. Flush=1 with CalcOp=34 valid -> DmEnable=0, DmWritesReg=0, state stays RUN, StallUp=0.
5. Flush=1 during LOAD_WAIT (MEM_LATENCY=3) -> load still held 3 cycles with DmEnable=1; the flush has no effect.
6. ResetN pulled low mid-LOAD_WAIT -> all outputs 0 immediately, MemBusy=0; after release, CalcOp=9, CalcDs=0 gives DmEnable=1, DmWritesReg=0.
